// File: rtl/case_3_mul_pkg.sv
// Shared definitions for the case_3 pipelined multiplier family.
//   mul_mode_e    : output narrowing mode (wrap or saturate)
//   MUL_STAGE_MIN : smallest legal pipeline depth
//   MUL_STAGE_MAX : largest legal pipeline depth
//   mul_range()   : representable [lo, hi] of a result of a given width/signedness
package case_3_mul_pkg;

    typedef enum logic {
        MUL_WRAP = 1'b0,
        MUL_SAT  = 1'b1
    } mul_mode_e;

    localparam int unsigned MUL_STAGE_MIN = 1;
    localparam int unsigned MUL_STAGE_MAX = 6;

    typedef struct packed {
        logic signed [63:0] lo;
        logic signed [63:0] hi;
    } mul_range_t;

    // Bounds are held in 64 bits, so result widths up to 62 bits are exact.
    function automatic mul_range_t mul_range(input int unsigned w, input bit out_signed);
        mul_range_t r;
        if (out_signed) begin
            r.lo = -(64'sd1 <<< (w - 1));
            r.hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        end else begin
            r.lo = '0;
            r.hi = (64'sd1 <<< w) - 64'sd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/case_3_mul_pipe_stage.sv
// One pipeline register of the multiplier with a tracked valid bit.
//   clk   : clock, rising edge
//   rst   : synchronous active-high clear of valid and data (wins over ce)
//   ce    : clock enable; 0 holds both valid and data
//   vld   : incoming data is a real operand/result
//   d     : incoming data
//   q_vld : registered valid
//   q     : registered data
module case_3_mul_pipe_stage
    import case_3_mul_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ce,
    input  logic         vld,
    input  logic [W-1:0] d,
    output logic         q_vld,
    output logic [W-1:0] q
);

    // Data only loads for valid entries, so bubbles leave the last result in place.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_vld <= 1'b0;
            q     <= '0;
        end else if (ce) begin
            q_vld <= vld;
            if (vld) begin
                q <= d;
            end
        end
    end

endmodule

// File: rtl/case_3_mul_pipe_sat.sv
// Pipelined multiplier with per-operand signedness, clock-enable stall,
// valid tracking and wrap/saturate narrowing with an overflow flag.
//   ap_clk    : clock, rising edge
//   ap_rst    : synchronous active-high reset, clears all valid bits, dout and ovf
//   ce        : clock enable; 0 freezes every pipeline register
//   in_valid  : din0/din1 carry a valid pair this cycle
//   din0      : operand 0 (signed if SIGNED0)
//   din1      : operand 1 (signed if SIGNED1)
//   out_valid : dout/ovf belong to a valid pair
//   dout      : narrowed product, registered
//   ovf       : exact product outside the dout range, registered
// Stage layout (NUM_STAGE = N):
//   N=1 : extend, multiply, narrow -> final register
//   N=2 : operand register -> multiply, narrow -> final register
//   N>=3: operand register -> multiply -> N-2 product registers -> narrow -> final register
module case_3_mul_pipe_sat
    import case_3_mul_pkg::*;
#(
    parameter int ID         = 1,
    parameter int NUM_STAGE  = 2,
    parameter int din0_WIDTH = 5,
    parameter int din1_WIDTH = 3,
    parameter int dout_WIDTH = 5,
    parameter int SIGNED0    = 1,
    parameter int SIGNED1    = 1,
    parameter int SAT_MODE   = 0
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  ce,
    input  logic                  in_valid,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  out_valid,
    output logic [dout_WIDTH-1:0] dout,
    output logic                  ovf
);

    // Extended operands together are exactly P bits wide, so every
    // intermediate stage carries P bits.
    localparam int unsigned P  = din0_WIDTH + din1_WIDTH + 2;
    localparam int unsigned CW = (dout_WIDTH + 2 > P) ? dout_WIDTH + 2 : P;

    localparam bit         OUT_SIGNED = (SIGNED0 != 0) || (SIGNED1 != 0);
    localparam bit         DO_SAT     = (SAT_MODE == int'(MUL_SAT));
    localparam mul_range_t RNG        = mul_range(dout_WIDTH, OUT_SIGNED);

    localparam logic signed [CW-1:0] LO = CW'(RNG.lo);
    localparam logic signed [CW-1:0] HI = CW'(RNG.hi);

    if (NUM_STAGE < int'(MUL_STAGE_MIN) || NUM_STAGE > int'(MUL_STAGE_MAX)) begin : g_bad_depth
        $error("case_3_mul_pipe_sat: NUM_STAGE %0d outside legal range", NUM_STAGE);
    end

    // ------------------------------------------------------------------
    // Operand extension
    // ------------------------------------------------------------------
    logic [din0_WIDTH:0] ext0;
    logic [din1_WIDTH:0] ext1;

    assign ext0 = (SIGNED0 != 0) ? {din0[din0_WIDTH-1], din0} : {1'b0, din0};
    assign ext1 = (SIGNED1 != 0) ? {din1[din1_WIDTH-1], din1} : {1'b0, din1};

    // ------------------------------------------------------------------
    // Operand stage (stage 1 when N >= 2)
    // ------------------------------------------------------------------
    logic [P-1:0] ops;
    logic         ops_vld;

    if (NUM_STAGE == 1) begin : g_ops_comb
        assign ops     = {ext0, ext1};
        assign ops_vld = in_valid;
    end else begin : g_ops_reg
        case_3_mul_pipe_stage #(
            .W (P)
        ) u_ops (
            .clk   (ap_clk),
            .rst   (ap_rst),
            .ce    (ce),
            .vld   (in_valid),
            .d     ({ext0, ext1}),
            .q_vld (ops_vld),
            .q     (ops)
        );
    end

    // ------------------------------------------------------------------
    // Exact signed product
    // ------------------------------------------------------------------
    logic signed [P-1:0] op_a;
    logic signed [P-1:0] op_b;
    logic signed [P-1:0] prod;

    assign op_a = P'($signed(ops[P-1 -: din0_WIDTH+1]));
    assign op_b = P'($signed(ops[din1_WIDTH:0]));
    assign prod = op_a * op_b;

    // ------------------------------------------------------------------
    // Product register chain (only when N >= 3)
    // ------------------------------------------------------------------
    logic signed [P-1:0] nar_src;
    logic                nar_vld;

    if (NUM_STAGE <= 2) begin : g_chain_none
        assign nar_src = prod;
        assign nar_vld = ops_vld;
    end else begin : g_chain
        logic [P-1:0] cq [NUM_STAGE-2];
        logic         cv [NUM_STAGE-2];

        for (genvar s = 0; s < NUM_STAGE - 2; s++) begin : g_s
            if (s == 0) begin : g_head
                case_3_mul_pipe_stage #(
                    .W (P)
                ) u_prod (
                    .clk   (ap_clk),
                    .rst   (ap_rst),
                    .ce    (ce),
                    .vld   (ops_vld),
                    .d     (prod),
                    .q_vld (cv[s]),
                    .q     (cq[s])
                );
            end else begin : g_tail
                case_3_mul_pipe_stage #(
                    .W (P)
                ) u_prod (
                    .clk   (ap_clk),
                    .rst   (ap_rst),
                    .ce    (ce),
                    .vld   (cv[s-1]),
                    .d     (cq[s-1]),
                    .q_vld (cv[s]),
                    .q     (cq[s])
                );
            end
        end

        assign nar_src = $signed(cq[NUM_STAGE-3]);
        assign nar_vld = cv[NUM_STAGE-3];
    end

    // ------------------------------------------------------------------
    // Narrowing and overflow
    // ------------------------------------------------------------------
    // The product is compared in a domain wide enough for both it and the
    // range bounds; when dout_WIDTH >= P-1 the bounds enclose every possible
    // product and ovf never asserts.
    logic signed [CW-1:0]  wide;
    logic                  under;
    logic                  over;
    logic [dout_WIDTH-1:0] nar_dout;
    logic                  nar_ovf;

    assign wide    = CW'(nar_src);
    assign under   = wide < LO;
    assign over    = wide > HI;
    assign nar_ovf = under | over;

    always_comb begin
        nar_dout = wide[dout_WIDTH-1:0];
        if (DO_SAT) begin
            if (under) begin
                nar_dout = LO[dout_WIDTH-1:0];
            end else if (over) begin
                nar_dout = HI[dout_WIDTH-1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Final (output) stage
    // ------------------------------------------------------------------
    logic [dout_WIDTH:0] res;

    case_3_mul_pipe_stage #(
        .W (dout_WIDTH + 1)
    ) u_out (
        .clk   (ap_clk),
        .rst   (ap_rst),
        .ce    (ce),
        .vld   (nar_vld),
        .d     ({nar_ovf, nar_dout}),
        .q_vld (out_valid),
        .q     (res)
    );

    assign ovf  = res[dout_WIDTH];
    assign dout = res[dout_WIDTH-1:0];

endmodule

// File: tb/tb_case_3_mul_pipe_sat.sv
module tb_case_3_mul_pipe_sat;

    logic       clk;
    logic       rst;
    logic       ce;
    logic       in_valid;
    logic [4:0] d0;
    logic [2:0] d1;
    logic [7:0] d0w;

    logic       sat_v, wrap_v;
    logic [4:0] sat_d, wrap_d;
    logic       sat_o, wrap_o;

    logic       n_v [3];
    logic [7:0] n_d [3];
    logic       n_o [3];

    int n_chk;
    int n_fail;

    case_3_mul_pipe_sat #(
        .ID(1), .NUM_STAGE(2), .din0_WIDTH(5), .din1_WIDTH(3), .dout_WIDTH(5),
        .SIGNED0(1), .SIGNED1(1), .SAT_MODE(1)
    ) u_sat (
        .ap_clk(clk), .ap_rst(rst), .ce(ce), .in_valid(in_valid),
        .din0(d0), .din1(d1), .out_valid(sat_v), .dout(sat_d), .ovf(sat_o)
    );

    case_3_mul_pipe_sat #(
        .ID(2), .NUM_STAGE(2), .din0_WIDTH(5), .din1_WIDTH(3), .dout_WIDTH(5),
        .SIGNED0(1), .SIGNED1(1), .SAT_MODE(0)
    ) u_wrap (
        .ap_clk(clk), .ap_rst(rst), .ce(ce), .in_valid(in_valid),
        .din0(d0), .din1(d1), .out_valid(wrap_v), .dout(wrap_d), .ovf(wrap_o)
    );

    case_3_mul_pipe_sat #(
        .ID(3), .NUM_STAGE(1), .din0_WIDTH(8), .din1_WIDTH(3), .dout_WIDTH(8),
        .SIGNED0(0), .SIGNED1(1), .SAT_MODE(1)
    ) u_n1 (
        .ap_clk(clk), .ap_rst(rst), .ce(ce), .in_valid(in_valid),
        .din0(d0w), .din1(d1), .out_valid(n_v[0]), .dout(n_d[0]), .ovf(n_o[0])
    );

    case_3_mul_pipe_sat #(
        .ID(4), .NUM_STAGE(3), .din0_WIDTH(8), .din1_WIDTH(3), .dout_WIDTH(8),
        .SIGNED0(0), .SIGNED1(1), .SAT_MODE(1)
    ) u_n3 (
        .ap_clk(clk), .ap_rst(rst), .ce(ce), .in_valid(in_valid),
        .din0(d0w), .din1(d1), .out_valid(n_v[1]), .dout(n_d[1]), .ovf(n_o[1])
    );

    case_3_mul_pipe_sat #(
        .ID(5), .NUM_STAGE(6), .din0_WIDTH(8), .din1_WIDTH(3), .dout_WIDTH(8),
        .SIGNED0(0), .SIGNED1(1), .SAT_MODE(1)
    ) u_n6 (
        .ap_clk(clk), .ap_rst(rst), .ce(ce), .in_valid(in_valid),
        .din0(d0w), .din1(d1), .out_valid(n_v[2]), .dout(n_d[2]), .ovf(n_o[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic [4:0] a;
        logic [2:0] b;
        logic [4:0] sat_d;
        logic       sat_o;
        logic [4:0] wrap_d;
        logic       wrap_o;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Integer reference for the default 5x3 -> 5 signed operator.
    function automatic void model(input logic [4:0] a, input logic [2:0] b, input bit sat,
                                  output logic [4:0] d, output logic o);
        int p;
        p = int'($signed(a)) * int'($signed(b));
        o = (p < -16) || (p > 15);
        if (sat && p > 15)       d = 5'b01111;
        else if (sat && p < -16) d = 5'b10000;
        else                     d = p[4:0];
    endfunction

    task automatic chk_pair(input string nm, input logic [4:0] a, input logic [2:0] b);
        logic [4:0] ed;
        logic       eo;
        model(a, b, 1'b1, ed, eo);
        chk({nm, " sat dout"}, 32'(sat_d), 32'(ed));
        chk({nm, " sat ovf"},  32'(sat_o), 32'(eo));
        model(a, b, 1'b0, ed, eo);
        chk({nm, " wrap dout"}, 32'(wrap_d), 32'(ed));
        chk({nm, " wrap ovf"},  32'(wrap_o), 32'(eo));
    endtask

    vec_t       tbl [14];
    logic [4:0] sa [8];
    logic [2:0] sb [8];
    logic [4:0] pa [3];
    logic [2:0] pb [3];
    int         lat [3];
    logic [7:0] got_d [3];
    logic       got_o [3];

    initial begin
        n_chk  = 0;
        n_fail = 0;

        tbl[0]  = '{5'(-16), 3'(-4), 5'b01111, 1'b1, 5'b00000, 1'b1};
        tbl[1]  = '{5'(7),   3'(3),  5'b01111, 1'b1, 5'b10101, 1'b1};
        tbl[2]  = '{5'(-16), 3'(3),  5'b10000, 1'b1, 5'b10000, 1'b1};
        tbl[3]  = '{5'(3),   3'(-2), 5'b11010, 1'b0, 5'b11010, 1'b0};
        tbl[4]  = '{5'(0),   3'(-4), 5'b00000, 1'b0, 5'b00000, 1'b0};
        tbl[5]  = '{5'(15),  3'(-4), 5'b10000, 1'b1, 5'b00100, 1'b1};
        tbl[6]  = '{5'(-1),  3'(-1), 5'b00001, 1'b0, 5'b00001, 1'b0};
        tbl[7]  = '{5'(5),   3'(3),  5'b01111, 1'b0, 5'b01111, 1'b0};
        tbl[8]  = '{5'(-16), 3'(1),  5'b10000, 1'b0, 5'b10000, 1'b0};
        tbl[9]  = '{5'(8),   3'(2),  5'b01111, 1'b1, 5'b10000, 1'b1};
        tbl[10] = '{5'(-16), 3'(-1), 5'b01111, 1'b1, 5'b10000, 1'b1};
        tbl[11] = '{5'(-3),  3'(-4), 5'b01100, 1'b0, 5'b01100, 1'b0};
        tbl[12] = '{5'(15),  3'(3),  5'b01111, 1'b1, 5'b01101, 1'b1};
        tbl[13] = '{5'(-11), 3'(2),  5'b10000, 1'b1, 5'b01010, 1'b1};

        rst = 1'b1; ce = 1'b1; in_valid = 1'b0; d0 = '0; d1 = '0; d0w = '0;

        // Reset state
        tick(); tick(); tick();
        chk("reset sat out_valid", 32'(sat_v), 0);
        chk("reset sat dout",      32'(sat_d), 0);
        chk("reset sat ovf",       32'(sat_o), 0);
        chk("reset wrap out_valid", 32'(wrap_v), 0);
        chk("reset wrap dout",     32'(wrap_d), 0);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset n%0d out_valid", k), 32'(n_v[k]), 0);
            chk($sformatf("reset n%0d dout", k),      32'(n_d[k]), 0);
        end
        rst = 1'b0;

        // Directed vectors, one at a time, two-cycle latency
        for (int i = 0; i < 14; i++) begin
            d0 = tbl[i].a; d1 = tbl[i].b; in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            chk($sformatf("tbl[%0d] mid out_valid", i), 32'(sat_v), 0);
            tick();
            chk($sformatf("tbl[%0d] out_valid", i), 32'(sat_v), 1);
            chk($sformatf("tbl[%0d] wrap out_valid", i), 32'(wrap_v), 1);
            chk($sformatf("tbl[%0d] sat dout", i),  32'(sat_d),  32'(tbl[i].sat_d));
            chk($sformatf("tbl[%0d] sat ovf", i),   32'(sat_o),  32'(tbl[i].sat_o));
            chk($sformatf("tbl[%0d] wrap dout", i), 32'(wrap_d), 32'(tbl[i].wrap_d));
            chk($sformatf("tbl[%0d] wrap ovf", i),  32'(wrap_o), 32'(tbl[i].wrap_o));
        end

        // Back-to-back stream of 8 random pairs
        for (int j = 0; j < 8; j++) begin
            sa[j] = 5'($urandom_range(0, 31));
            sb[j] = 3'($urandom_range(0, 7));
        end
        for (int t = 1; t <= 10; t++) begin
            if (t <= 8) begin
                d0 = sa[t-1]; d1 = sb[t-1]; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            chk($sformatf("stream t%0d out_valid", t), 32'(sat_v), 32'((t >= 2) && (t <= 9)));
            if (t >= 2 && t <= 9) begin
                chk_pair($sformatf("stream pair%0d", t - 2), sa[t-2], sb[t-2]);
            end
        end

        // Stall: ce low for 4 cycles between pair 1 and pair 2
        pa[0] = 5'(7);  pb[0] = 3'(3);
        pa[1] = 5'(-5); pb[1] = 3'(2);
        pa[2] = 5'(6);  pb[2] = 3'(-3);
        for (int t = 1; t <= 9; t++) begin
            ce       = !(t >= 3 && t <= 6);
            in_valid = (t <= 7);
            if (t == 1)      begin d0 = pa[0]; d1 = pb[0]; end
            else if (t == 2) begin d0 = pa[1]; d1 = pb[1]; end
            else if (t == 7) begin d0 = pa[2]; d1 = pb[2]; end
            else             begin d0 = 5'b01011; d1 = 3'b011; end
            tick();
            if (t == 1 || t == 9) begin
                chk($sformatf("stall t%0d out_valid", t), 32'(sat_v), 0);
            end else begin
                chk($sformatf("stall t%0d out_valid", t), 32'(sat_v), 1);
                if (t <= 6)      chk_pair($sformatf("stall t%0d pair0", t), pa[0], pb[0]);
                else if (t == 7) chk_pair("stall t7 pair1", pa[1], pb[1]);
                else             chk_pair("stall t8 pair2", pa[2], pb[2]);
            end
        end
        ce = 1'b1; in_valid = 1'b0;

        // Reset mid-flight, once with ce=1 and once with ce=0
        for (int r = 0; r < 2; r++) begin
            ce = 1'b1;
            d0 = 5'(7); d1 = 3'(3); in_valid = 1'b1;
            tick();
            d0 = 5'(-16); d1 = 3'(-4);
            tick();
            chk($sformatf("rst%0d pre out_valid", r), 32'(sat_v), 1);
            rst = 1'b1; ce = (r == 0); d0 = 5'(3); d1 = 3'(-2);
            tick();
            chk($sformatf("rst%0d out_valid", r), 32'(sat_v), 0);
            chk($sformatf("rst%0d sat dout", r),  32'(sat_d), 0);
            chk($sformatf("rst%0d sat ovf", r),   32'(sat_o), 0);
            chk($sformatf("rst%0d wrap dout", r), 32'(wrap_d), 0);
            chk($sformatf("rst%0d wrap ovf", r),  32'(wrap_o), 0);
            rst = 1'b0; ce = 1'b1; in_valid = 1'b0;
            for (int t = 0; t < 3; t++) begin
                tick();
                chk($sformatf("rst%0d post t%0d out_valid", r, t), 32'(sat_v), 0);
                chk($sformatf("rst%0d post t%0d wrap out_valid", r, t), 32'(wrap_v), 0);
            end
        end

        // Depth sweep: 255 * -1 into a signed 8-bit result
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            lat[k] = -1; got_d[k] = '0; got_o[k] = 1'b0;
        end
        for (int t = 1; t <= 10; t++) begin
            if (t == 1) begin
                d0w = 8'd255; d1 = 3'b111; in_valid = 1'b1;
            end else begin
                d0w = '0; in_valid = 1'b0;
            end
            tick();
            for (int k = 0; k < 3; k++) begin
                if (lat[k] < 0 && n_v[k]) begin
                    lat[k] = t; got_d[k] = n_d[k]; got_o[k] = n_o[k];
                end
            end
        end
        chk("sweep N=1 latency", 32'(lat[0]), 1);
        chk("sweep N=3 latency", 32'(lat[1]), 3);
        chk("sweep N=6 latency", 32'(lat[2]), 6);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("sweep n%0d dout", k), 32'(got_d[k]), 32'h80);
            chk($sformatf("sweep n%0d ovf", k),  32'(got_o[k]), 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
